// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_dbg_pkg: shared types and constants for the CPU clock-enable / debug
// run controller and its key debouncer.
//   run_mode_t       : FULL, DIV, STEP, HALT operating modes
//   run_state_t      : RUN, BP_HALT controller states
//   DEFAULT_DEBOUNCE : 10 ms of a 50 MHz board clock
//   clamp_tap()      : limits a prescaler tap index to the counter width
package cpu_dbg_pkg;

    typedef enum logic [1:0] {FULL, DIV, STEP, HALT} run_mode_t;
    typedef enum logic {RUN, BP_HALT} run_state_t;

    localparam int DEFAULT_DEBOUNCE = 500000;

    function automatic int clamp_tap(input int sel, input int width);
        return (sel >= width) ? width - 1 : sel;
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: run-control bundle between the board/debug side and the
// clock controller.
//   master : drives mode, div_sel, step_key, resume, bp_enable, bp_addr,
//            pc, fetch; observes cpu_enable, halted, bp_hit, enable_count
//   slave  : the controller side (directions mirrored)
interface cpu_clock_ctrl_if
    import cpu_dbg_pkg::*;
#(
    parameter int DIV_WIDTH = 27,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
) ();

    run_mode_t                      mode;
    logic [$clog2(DIV_WIDTH)-1:0]   div_sel;
    logic                           step_key;
    logic                           resume;
    logic                           bp_enable;
    logic [PC_WIDTH-1:0]            bp_addr;
    logic [PC_WIDTH-1:0]            pc;
    logic                           fetch;
    logic                           cpu_enable;
    logic                           halted;
    logic                           bp_hit;
    logic [CNT_WIDTH-1:0]           enable_count;

    modport master (
        output mode, div_sel, step_key, resume, bp_enable, bp_addr, pc, fetch,
        input  cpu_enable, halted, bp_hit, enable_count
    );

    modport slave (
        input  mode, div_sel, step_key, resume, bp_enable, bp_addr, pc, fetch,
        output cpu_enable, halted, bp_hit, enable_count
    );

endinterface

// File: rtl/cpu_clock_ctrl_key_debounce.sv
// key_debounce: two-flop synchroniser plus hold-time debouncer for a
// mechanical key.
//   clock : board clock
//   reset : asynchronous, active-high
//   raw   : unsynchronised key level
//   level : debounced key level
//   rise  : one-cycle pulse when level goes 0 -> 1
module key_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          settle;

    // The new level has been stable long enough to be accepted this cycle.
    assign settle = (sync2 != level) && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any bounce back to the accepted level restarts the hold timer.
            if (sync2 == level || settle)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (settle)
                level <= sync2;
            rise <= settle & sync2;
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable generator and debug run controller.
//   clock : board clock (rising edge)
//   reset : asynchronous, active-high
//   bus   : cpu_clock_ctrl_if.slave
//           in : mode, div_sel, step_key, resume, bp_enable, bp_addr, pc, fetch
//           out: cpu_enable (1-cycle advance pulse), halted, bp_hit (sticky),
//                enable_count (wrapping count of issued enables)
module cpu_clock_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DIV_WIDTH       = 27,
    parameter int PC_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_WIDTH       = 32
) (
    input  logic             clock,
    input  logic             reset,
    cpu_clock_ctrl_if.slave  bus
);

    localparam int SEL_W = $clog2(DIV_WIDTH);

    logic [DIV_WIDTH-1:0] presc;
    logic [SEL_W-1:0]     tap_idx;
    logic                 tap_q;
    logic                 tick;

    logic                 unused_step_level;
    logic                 step_req;

    run_mode_t            mode_q;
    run_state_t           state;
    run_state_t           state_n;
    logic                 resume_q;
    logic                 resume_rise;
    logic                 suppress;
    logic                 bp_match;
    logic                 bp_trig;
    logic                 cand;

    logic                 cpu_enable_q;
    logic                 halted_q;
    logic                 bp_hit_q;
    logic [CNT_WIDTH-1:0] count_q;

    // Prescaler with registered edge detect on the selected tap.
    assign tap_idx = SEL_W'(clamp_tap(int'(bus.div_sel), DIV_WIDTH));
    assign tick    = presc[tap_idx] & ~tap_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tap_q <= 1'b0;
        end else begin
            presc <= presc + DIV_WIDTH'(1);
            tap_q <= presc[tap_idx];
        end
    end

    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_step_key (
        .clock (clock),
        .reset (reset),
        .raw   (bus.step_key),
        .level (unused_step_level),
        .rise  (step_req)
    );

    assign resume_rise = bus.resume & ~resume_q;
    assign bp_match    = (bus.pc[PC_WIDTH-1:0] == bus.bp_addr[PC_WIDTH-1:0]);
    // The enable that fetched the breakpoint instruction must be live; the
    // first cycle back in RUN is exempt so a resume at bp_addr can proceed.
    assign bp_trig     = (state == RUN) && bus.bp_enable && bus.fetch &&
                         bp_match && cpu_enable_q && !suppress;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cand    = 1'b0;
        case (state)
            RUN: begin
                if (bp_trig) begin
                    state_n = BP_HALT;
                end else if (bus.mode == mode_q) begin
                    // A mode change drops whatever was pending this cycle.
                    case (mode_q)
                        FULL:    cand = 1'b1;
                        DIV:     cand = tick;
                        STEP:    cand = step_req;
                        default: cand = 1'b0;
                    endcase
                end
            end
            BP_HALT: begin
                if (resume_rise)
                    state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q       <= FULL;
            resume_q     <= 1'b0;
            suppress     <= 1'b0;
            cpu_enable_q <= 1'b0;
            halted_q     <= 1'b0;
            bp_hit_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            mode_q       <= bus.mode;
            resume_q     <= bus.resume;
            suppress     <= (state == BP_HALT) && (state_n == RUN);
            cpu_enable_q <= cand;
            halted_q     <= (state_n == BP_HALT) || (mode_q == HALT) ||
                            ((mode_q == STEP) && !cand);
            if (bp_trig)
                bp_hit_q <= 1'b1;
            else if ((state == BP_HALT) && (state_n == RUN))
                bp_hit_q <= 1'b0;
            count_q      <= count_q + CNT_WIDTH'(cpu_enable_q);
        end
    end

    assign bus.cpu_enable   = cpu_enable_q;
    assign bus.halted       = halted_q;
    assign bus.bp_hit       = bp_hit_q;
    assign bus.enable_count = count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: scoreboard bench for cpu_clock_ctrl with a short
// prescaler, short debounce and a 4-bit enable counter.
module tb_cpu_clock_ctrl;
    import cpu_dbg_pkg::*;

    localparam int DIV_WIDTH = 8;
    localparam int PC_WIDTH  = 16;
    localparam int DEB       = 8;
    localparam int CNT_WIDTH = 4;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    logic     clock;
    logic     reset;
    sb_item_t sb_q[$];
    int       pulse_cyc[$];
    int       pulses;
    int       cyc;
    int       n_checks;
    int       n_errors;
    int       c0;

    cpu_clock_ctrl_if #(
        .DIV_WIDTH (DIV_WIDTH),
        .PC_WIDTH  (PC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) bus ();

    cpu_clock_ctrl #(
        .DIV_WIDTH       (DIV_WIDTH),
        .PC_WIDTH        (PC_WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (CNT_WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, obs, it.val);
        end
    endtask

    // Advance n cycles, sampling 1 ns after each falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
            cyc++;
            if (bus.cpu_enable === 1'b1) begin
                pulses++;
                pulse_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic clear_pulses();
        pulses = 0;
        pulse_cyc.delete();
    endtask

    task automatic expect_outputs_zero(input string pfx);
        sb_push({pfx, "_en"}, 32'd0);
        sb_push({pfx, "_halted"}, 32'd0);
        sb_push({pfx, "_hit"}, 32'd0);
        sb_push({pfx, "_cnt"}, 32'd0);
        sb_pop(32'(bus.cpu_enable));
        sb_pop(32'(bus.halted));
        sb_pop(32'(bus.bp_hit));
        sb_pop(32'(bus.enable_count));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        clear_pulses();
        reset         = 1'b1;
        bus.mode      = FULL;
        bus.div_sel   = '0;
        bus.step_key  = 1'b0;
        bus.resume    = 1'b0;
        bus.bp_enable = 1'b0;
        bus.bp_addr   = 16'h0010;
        bus.pc        = 16'h0000;
        bus.fetch     = 1'b0;

        #3;
        expect_outputs_zero("rst");

        // FULL mode from reset, including counter wrap
        step(2);
        reset = 1'b0;
        clear_pulses();
        step(16);
        sb_push("wrap_pre", 32'd15);
        sb_pop(32'(bus.enable_count));
        step(1);
        sb_push("wrap_zero", 32'd0);
        sb_pop(32'(bus.enable_count));
        step(83);
        sb_push("full_cnt", 32'(99 % 16));
        sb_push("full_pulses", 32'd100);
        sb_push("full_halted", 32'd0);
        sb_pop(32'(bus.enable_count));
        sb_pop(32'(pulses));
        sb_pop(32'(bus.halted));

        // DIV mode, tap 3 -> one pulse per 16 cycles
        bus.mode    = DIV;
        bus.div_sel = 3'd3;
        step(40);
        clear_pulses();
        step(80);
        sb_push("div_n", 32'd5);
        sb_pop(32'(pulses));
        for (int i = 1; i < 5; i++) begin
            sb_push("div_gap", 32'd16);
            if (i < pulse_cyc.size())
                sb_pop(32'(pulse_cyc[i] - pulse_cyc[i-1]));
            else
                sb_pop(32'd0);
        end

        // HALT mode
        bus.mode = HALT;
        step(3);
        clear_pulses();
        step(10);
        sb_push("halt_n", 32'd0);
        sb_push("halt_halted", 32'd1);
        sb_pop(32'(pulses));
        sb_pop(32'(bus.halted));

        // STEP mode: clean press and its latency
        bus.mode = STEP;
        step(20);
        clear_pulses();
        sb_push("step_idle_halted", 32'd1);
        sb_pop(32'(bus.halted));
        c0 = cyc;
        bus.step_key = 1'b1;
        step(25);
        sb_push("step_n", 32'd1);
        sb_pop(32'(pulses));
        sb_push("step_lat", 32'(c0 + DEB + 3));
        sb_pop((pulse_cyc.size() > 0) ? 32'(pulse_cyc[0]) : 32'd0);
        bus.step_key = 1'b0;
        step(20);

        // Bouncy press: toggling every 3 cycles, then held
        clear_pulses();
        for (int i = 0; i < 7; i++) begin
            bus.step_key = ~bus.step_key;
            step(3);
        end
        step(30);
        sb_push("bounce_n", 32'd1);
        sb_pop(32'(pulses));
        bus.step_key = 1'b0;
        step(20);

        // Press shorter than the debounce window
        clear_pulses();
        bus.step_key = 1'b1;
        step(5);
        bus.step_key = 1'b0;
        step(25);
        sb_push("short_n", 32'd0);
        sb_pop(32'(pulses));

        // Breakpoint in FULL mode
        bus.mode      = FULL;
        bus.bp_enable = 1'b1;
        bus.fetch     = 1'b1;
        bus.pc        = 16'h0000;
        step(5);
        bus.pc = 16'h0010;
        step(1);
        sb_push("bp_hit", 32'd1);
        sb_push("bp_halted", 32'd1);
        sb_push("bp_en", 32'd0);
        sb_pop(32'(bus.bp_hit));
        sb_pop(32'(bus.halted));
        sb_pop(32'(bus.cpu_enable));

        // Step key is ignored while halted on the breakpoint
        bus.mode = STEP;
        step(2);
        clear_pulses();
        bus.step_key = 1'b1;
        step(20);
        sb_push("bp_step_n", 32'd0);
        sb_push("bp_step_halted", 32'd1);
        sb_pop(32'(pulses));
        sb_pop(32'(bus.halted));
        bus.step_key = 1'b0;
        bus.mode     = FULL;
        step(20);

        // Resume: back to RUN, no immediate re-halt at the same pc
        bus.resume = 1'b1;
        step(1);
        bus.resume = 1'b0;
        sb_push("res_hit", 32'd0);
        sb_push("res_halted", 32'd0);
        sb_pop(32'(bus.bp_hit));
        sb_pop(32'(bus.halted));
        step(1);
        sb_push("res_en", 32'd1);
        sb_push("res_hit2", 32'd0);
        sb_pop(32'(bus.cpu_enable));
        sb_pop(32'(bus.bp_hit));
        bus.fetch = 1'b0;
        clear_pulses();
        step(5);
        sb_push("run_n", 32'd5);
        sb_push("run_hit", 32'd0);
        sb_pop(32'(pulses));
        sb_pop(32'(bus.bp_hit));

        // Re-halt, then asynchronous reset mid-cycle
        bus.fetch = 1'b1;
        step(1);
        sb_push("bp2_hit", 32'd1);
        sb_pop(32'(bus.bp_hit));
        #2;
        reset = 1'b1;
        #1;
        expect_outputs_zero("async_rst");
        step(1);
        reset         = 1'b0;
        bus.bp_enable = 1'b0;
        step(3);
        sb_push("post_rst_en", 32'd1);
        sb_push("post_rst_hit", 32'd0);
        sb_pop(32'(bus.cpu_enable));
        sb_pop(32'(bus.bp_hit));

        check("sb_left", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
